// File: rtl/ifid_stall_stage.sv
// IF/ID pipeline register with load-use stall and branch flush handling.
// Also tracks stall run length, a sticky runaway-stall flag and perf counters.
module ifid_stall_stage #(
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               if_valid,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               pc_write,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [4:0]         id_rs,
  output logic [4:0]         id_rt,
  output logic               ex_bubble,
  output logic               holding,
  output logic               stall_timeout,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   bubble_count
);

  localparam int RL_W =
    (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RL_W-1:0] RL_MAX =
    RL_W'(MAX_STALL);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [RL_W-1:0]      rl_q, rl_d;
  logic                 valid_q, valid_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 tmo_q, tmo_d;
  logic [CNT_W-1:0]     scnt_q, scnt_d;
  logic [CNT_W-1:0]     bcnt_q, bcnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rl_q    <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      tmo_q   <= 1'b0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rl_q    <= rl_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rl_d    = rl_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    tmo_d   = tmo_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;

    if (stall || flush) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end

    // Flush outranks stall: a squashed slot never holds.
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = '0;
      state_d = RUN;
      rl_d    = '0;
    end else if (stall) begin
      state_d = HOLD;
      scnt_d  = scnt_q + CNT_W'(1);
      if (state_q == HOLD && rl_q != RL_MAX) begin
        rl_d = rl_q + RL_W'(1);
      end
      if (rl_d == RL_MAX) begin
        tmo_d = 1'b1;
      end
    end else begin
      valid_d = if_valid;
      pc_d    = if_pc;
      instr_d = if_valid ? if_instr : '0;
      state_d = RUN;
      rl_d    = '0;
    end
  end

  assign pc_write      = ~reset & (flush | ~stall);
  assign ex_bubble     = reset | stall | flush;
  assign id_valid      = valid_q;
  assign id_pc         = pc_q;
  assign id_instr      = instr_q;
  assign id_rs         = instr_q[25:21];
  assign id_rt         = instr_q[20:16];
  assign holding       = (state_q == HOLD);
  assign stall_timeout = tmo_q;
  assign stall_count   = scnt_q;
  assign bubble_count  = bcnt_q;

endmodule

// File: tb/tb_ifid_stall_stage.sv
// Self-checking bench for ifid_stall_stage: directed vectors, corner
// sequences and random traffic against a behavioural model.
module tb_ifid_stall_stage;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, if_valid;
  logic [31:0] if_pc, if_instr;
  logic        pc_write, id_valid, ex_bubble, holding, stall_timeout;
  logic [31:0] id_pc, id_instr;
  logic [4:0]  id_rs, id_rt;
  logic [15:0] stall_count, bubble_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic        m_valid;
  logic [31:0] m_pc, m_instr;
  int          m_run;
  logic        m_tmo;
  logic [15:0] m_sc, m_bc;

  ifid_stall_stage #(
    .PC_W(32), .INSTR_W(32), .CNT_W(16), .MAX_STALL(MAXS)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .pc_write(pc_write), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_rs(id_rs), .id_rt(id_rt),
    .ex_bubble(ex_bubble), .holding(holding),
    .stall_timeout(stall_timeout), .stall_count(stall_count),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, f, v;
    logic [31:0] pc, instr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    logic        e_pw, e_bub;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_instr = 0;
    m_run = 0; m_tmo = 0; m_sc = 0; m_bc = 0;
  endtask

  task automatic model_edge(input logic s, f, v,
                            input logic [31:0] pc, instr);
    if (f) begin
      m_bc++;
      m_valid = 0; m_pc = 0; m_instr = 0; m_run = 0;
    end else if (s) begin
      m_bc++; m_sc++; m_run++;
      if (m_run > MAXS) m_tmo = 1;
    end else begin
      m_valid = v; m_pc = pc; m_instr = v ? instr : 32'h0;
      m_run = 0;
    end
  endtask

  task automatic check_model();
    check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    check("id_pc", id_pc, m_pc);
    check("id_instr", id_instr, m_instr);
    check("id_rs", {27'b0, id_rs}, {27'b0, m_instr[25:21]});
    check("id_rt", {27'b0, id_rt}, {27'b0, m_instr[20:16]});
    check("holding", {31'b0, holding}, {31'b0, (m_run > 0)});
    check("timeout", {31'b0, stall_timeout}, {31'b0, m_tmo});
    check("stall_count", {16'b0, stall_count}, {16'b0, m_sc});
    check("bubble_count", {16'b0, bubble_count}, {16'b0, m_bc});
  endtask

  // Drive one cycle, check comb outputs, clock, then check state.
  task automatic step(input logic s, f, v,
                      input logic [31:0] pc, instr);
    stall = s; flush = f; if_valid = v; if_pc = pc; if_instr = instr;
    #1;
    check("pc_write", {31'b0, pc_write}, {31'b0, (f | ~s)});
    check("ex_bubble", {31'b0, ex_bubble}, {31'b0, (s | f)});
    @(posedge clk);
    model_edge(s, f, v, pc, instr);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; flush = 0; if_valid = 0;
    if_pc = 0; if_instr = 0;
    #1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    vecs[0] = '{0,0,1,32'h0, 32'h8C220000, 1,32'h0, 32'h8C220000,1,0};
    vecs[1] = '{0,0,1,32'h4, 32'h00430820, 1,32'h4, 32'h00430820,1,0};
    vecs[2] = '{1,0,1,32'h8, 32'h00221820, 1,32'h4, 32'h00430820,0,1};
    vecs[3] = '{0,0,1,32'h8, 32'h00221820, 1,32'h8, 32'h00221820,1,0};
    vecs[4] = '{1,1,1,32'hC, 32'h11111111, 0,32'h0, 32'h0,       1,1};
    vecs[5] = '{0,0,0,32'h10,32'hFFFFFFFF, 0,32'h10,32'h0,       1,0};
    vecs[6] = '{0,0,1,32'h14,32'h03E00008, 1,32'h14,32'h03E00008,1,0};

    // T1 reset
    reset = 1; stall = 1; flush = 0; if_valid = 1;
    if_pc = 32'h40; if_instr = 32'hDEADBEEF;
    #1;
    model_reset();
    check("rst_pc_write", {31'b0, pc_write}, 32'd0);
    check("rst_ex_bubble", {31'b0, ex_bubble}, 32'd1);
    @(posedge clk); #1;
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_counts", {stall_count, bubble_count}, 32'd0);
    check("rst_timeout", {31'b0, stall_timeout}, 32'd0);
    stall = 0; if_valid = 0;
    reset = 0;
    #1;
    check("rel_pc_write", {31'b0, pc_write}, 32'd1);
    check("rel_ex_bubble", {31'b0, ex_bubble}, 32'd0);

    // T2-T4 directed table
    for (int i = 0; i < 7; i++) begin
      logic [31:0] ei;
      stall = vecs[i].s; flush = vecs[i].f; if_valid = vecs[i].v;
      if_pc = vecs[i].pc; if_instr = vecs[i].instr;
      #1;
      check("tbl_pc_write", {31'b0, pc_write}, {31'b0, vecs[i].e_pw});
      check("tbl_ex_bubble", {31'b0, ex_bubble}, {31'b0, vecs[i].e_bub});
      @(posedge clk);
      model_edge(vecs[i].s, vecs[i].f, vecs[i].v,
                 vecs[i].pc, vecs[i].instr);
      #1;
      ei = vecs[i].e_instr;
      check("tbl_id_valid", {31'b0, id_valid}, {31'b0, vecs[i].e_valid});
      check("tbl_id_pc", id_pc, vecs[i].e_pc);
      check("tbl_id_instr", id_instr, ei);
      check("tbl_id_rs", {27'b0, id_rs}, {27'b0, ei[25:21]});
      check("tbl_id_rt", {27'b0, id_rt}, {27'b0, ei[20:16]});
      if (i == 4) check("tbl_holding", {31'b0, holding}, 32'd0);
    end
    check("tbl_stall_count", {16'b0, stall_count}, 32'd1);
    check("tbl_bubble_count", {16'b0, bubble_count}, 32'd2);

    // T5 runaway stall: flag rises on 5th stalled edge and sticks
    do_reset();
    step(0, 0, 1, 32'h100, 32'h8C430004);
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 1, 32'h104, 32'h00640820);
      check("t5_timeout", {31'b0, stall_timeout}, {31'b0, (k >= 5)});
      check("t5_id_instr", id_instr, 32'h8C430004);
    end
    step(0, 0, 1, 32'h104, 32'h00640820);
    check("t5_sticky", {31'b0, stall_timeout}, 32'd1);
    check("t5_stall_count", {16'b0, stall_count}, 32'd6);
    check("t5_bubble_count", {16'b0, bubble_count}, 32'd6);
    step(1, 1, 1, 32'h108, 32'h0);
    check("t5_sticky_flush", {31'b0, stall_timeout}, 32'd1);

    // T6 reset in the middle of a HOLD
    do_reset();
    step(0, 0, 1, 32'h200, 32'h8C220010);
    step(1, 0, 1, 32'h204, 32'h00221820);
    step(1, 0, 1, 32'h204, 32'h00221820);
    check("t6_holding_pre", {31'b0, holding}, 32'd1);
    #2;
    reset = 1;
    #1;
    model_reset();
    check("t6_holding", {31'b0, holding}, 32'd0);
    check("t6_id_valid", {31'b0, id_valid}, 32'd0);
    check("t6_id_instr", id_instr, 32'd0);
    check("t6_counts", {stall_count, bubble_count}, 32'd0);
    check("t6_pc_write", {31'b0, pc_write}, 32'd0);
    @(posedge clk); #1;
    reset = 0;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic s, f, v;
      s = ($urandom_range(0, 99) < 35);
      f = ($urandom_range(0, 99) < 8);
      v = ($urandom_range(0, 99) < 80);
      if (n == 200) begin
        do_reset();
      end
      step(s, f, v, $urandom & 32'hFFFFFFFC, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

endmodule
